// File: rtl/hsi_rx_pkg.sv
// hsi_rx_pkg: shared types and bit positions for the HSI receive controller.
//   rx_state_e   : controller FSM states
//   ERR_*        : bit positions inside the checker's rx_errs vector
//   RC_*         : bit positions inside resp_code
//   mk_resp_code : builds resp_code from the error snapshot and overflow flag
package hsi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_END,
    ST_REPORT,
    ST_HOLD
  } rx_state_e;

  localparam int ERR_W      = 6;
  localparam int ERR_OK     = 0;
  localparam int ERR_MARKER = 1;
  localparam int ERR_FLAG   = 2;
  localparam int ERR_LEN    = 3;
  localparam int ERR_PARITY = 4;
  localparam int ERR_CRC    = 5;

  localparam int RC_OK      = 7;
  localparam int RC_OVF     = 6;
  localparam int RC_ERR_LSB = 0;

  // A message is only reported ok when the checker says ok and it did not
  // overflow; the raw error vector is always carried along.
  function automatic logic [7:0] mk_resp_code(input logic [ERR_W-1:0] errs,
                                              input logic             ovf);
    logic [7:0] c;
    c                     = '0;
    c[RC_OK]              = errs[ERR_OK] & ~ovf;
    c[RC_OVF]             = ovf;
    c[RC_ERR_LSB +: ERR_W] = errs;
    return c;
  endfunction

endpackage

// File: rtl/hsi_gap_timer.sv
// hsi_gap_timer: idle-gap counter for the receive controller.
//   clk, n_rst : clock, async active-low reset
//   i_load     : a byte arrived, restart the gap from zero
//   i_clr      : not receiving, hold the counter at zero
//   i_inc      : count one idle cycle
//   o_tc       : counter is at GAP_TICKS-1 (gap about to expire)
module hsi_gap_timer #(
  parameter int GAP_TICKS = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(GAP_TICKS + 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(GAP_TICKS - 1));

  // Parks at terminal count rather than wrapping, so a stalled caller can
  // never see the gap "un-expire".
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                r_cnt <= '0;
    else if (i_clr || i_load)  r_cnt <= '0;
    else if (i_inc && !o_tc)   r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/hsi_rx_ctrl.sv
// hsi_rx_ctrl: frames received bytes into messages (idle gap or byte-count
// overflow), hands the checker a message-end pulse, and reports the result
// to the transmitter through a valid/ready handshake followed by a holdoff.
//   clk, n_rst  : clock, async active-low reset
//   d_rdy       : one-cycle byte strobe from the byte receiver
//   rx_errs     : checker error vector, sampled in the rx_msg_end cycle
//   rx_flg      : checker flag byte, sampled in the rx_msg_end cycle
//   rx_en       : byte receiver enable
//   rx_msg_end  : one-cycle message-end pulse to the checker
//   resp_valid  : response available
//   resp_ready  : transmitter accepts the response
//   resp_code   : {ok, overflow, rx_errs}
//   msg_flg     : rx_flg latched at message end
//   bad_cnt     : saturating count of non-ok messages
module hsi_rx_ctrl
  import hsi_rx_pkg::*;
#(
  parameter int GAP_TICKS = 64,
  parameter int MAX_BYTES = 70,
  parameter int HOLDOFF   = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_rdy,
  input  logic [5:0] rx_errs,
  input  logic [7:0] rx_flg,
  output logic       rx_en,
  output logic       rx_msg_end,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_code,
  output logic [7:0] msg_flg,
  output logic [7:0] bad_cnt
);

  localparam int HW = $clog2(HOLDOFF + 1);

  rx_state_e     r_state, w_next;
  logic [6:0]    r_byte_cnt;
  logic [6:0]    w_cnt_inc;
  logic          r_ovf;
  logic          w_ovf_hit;
  logic [HW-1:0] r_hold_cnt;
  logic          r_rx_en;
  logic [7:0]    r_resp_code;
  logic [7:0]    r_msg_flg;
  logic [7:0]    r_bad_cnt;
  logic [7:0]    w_code;
  logic          w_tc;
  logic          w_tmr_load;
  logic          w_tmr_clr;
  logic          w_tmr_inc;
  logic          w_msg_end;
  logic          w_resp_valid;

  assign w_cnt_inc = r_byte_cnt + 7'd1;
  assign w_code    = mk_resp_code(rx_errs, r_ovf);

  // Timer only runs while a message is open; any accepted byte restarts it.
  assign w_tmr_load = d_rdy && ((r_state == ST_IDLE) || (r_state == ST_RECV));
  assign w_tmr_clr  = (r_state != ST_RECV);
  assign w_tmr_inc  = (r_state == ST_RECV);

  hsi_gap_timer #(.GAP_TICKS(GAP_TICKS)) u_gap (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_load (w_tmr_load),
    .i_clr  (w_tmr_clr),
    .i_inc  (w_tmr_inc),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_next       = r_state;
    w_ovf_hit    = 1'b0;
    w_msg_end    = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_rdy) w_next = ST_RECV;
      end
      ST_RECV: begin
        // A byte in the terminal-count cycle wins over the gap expiring.
        if (d_rdy) begin
          if (w_cnt_inc == 7'(MAX_BYTES)) begin
            w_next    = ST_END;
            w_ovf_hit = 1'b1;
          end
        end else if (w_tc) begin
          w_next = ST_END;
        end
      end
      ST_END: begin
        w_msg_end = 1'b1;
        w_next    = ST_REPORT;
      end
      ST_REPORT: begin
        w_resp_valid = 1'b1;
        if (resp_ready) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hold_cnt == HW'(HOLDOFF - 1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_rx_en     <= 1'b0;
      r_byte_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_hold_cnt  <= '0;
      r_resp_code <= '0;
      r_msg_flg   <= '0;
      r_bad_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Registered from the next state so the enable drops in the same cycle
      // the overflow byte count lands, and rises one clk after reset.
      r_rx_en <= (w_next == ST_IDLE) || (w_next == ST_RECV);

      if (r_state == ST_IDLE && d_rdy)       r_byte_cnt <= 7'd1;
      else if (r_state == ST_RECV && d_rdy)  r_byte_cnt <= w_cnt_inc;
      else if (r_state == ST_HOLD && w_next == ST_IDLE) r_byte_cnt <= '0;

      if (w_ovf_hit)                                  r_ovf <= 1'b1;
      else if (r_state == ST_HOLD && w_next == ST_IDLE) r_ovf <= 1'b0;

      if (r_state == ST_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
      else                    r_hold_cnt <= '0;

      if (r_state == ST_END) begin
        r_resp_code <= w_code;
        r_msg_flg   <= rx_flg;
        if (!w_code[RC_OK] && (r_bad_cnt != 8'hFF)) r_bad_cnt <= r_bad_cnt + 8'd1;
      end
    end
  end

  assign rx_en      = r_rx_en;
  assign rx_msg_end = w_msg_end;
  assign resp_valid = w_resp_valid;
  assign resp_code  = r_resp_code;
  assign msg_flg    = r_msg_flg;
  assign bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_hsi_rx_ctrl.sv
// tb_hsi_rx_ctrl: directed stimulus plus a deadline-based reference model.
// The model tracks when the receiver is open, the cycle of the last byte
// and the cycle at which the message must end, and is compared against the
// DUT every cycle; literal checks pin the headline latencies and codes.
module tb_hsi_rx_ctrl;

  localparam int GAP   = 64;
  localparam int MAXB  = 70;
  localparam int HOLD  = 16;
  localparam int NEVER = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_rdy = 1'b0;
  logic       resp_ready = 1'b0;
  logic [5:0] rx_errs = '0;
  logic [7:0] rx_flg = '0;
  logic       rx_en, rx_msg_end, resp_valid;
  logic [7:0] resp_code, msg_flg, bad_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  hsi_rx_ctrl #(.GAP_TICKS(GAP), .MAX_BYTES(MAXB), .HOLDOFF(HOLD)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_rdy      (d_rdy),
    .rx_errs    (rx_errs),
    .rx_flg     (rx_flg),
    .rx_en      (rx_en),
    .rx_msg_end (rx_msg_end),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_code  (resp_code),
    .msg_flg    (msg_flg),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_started = 0, m_rep = 0, m_ovf = 0, m_en_prev = 0, exp_en;
  int         m_avail = NEVER, m_end = NEVER, m_last = 0, m_nb = 0;
  logic [7:0] m_code = '0, m_flg = '0, m_bad = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!n_rst) begin
        m_started = 0; m_rep = 0; m_ovf = 0; m_avail = NEVER; m_end = NEVER;
        m_nb = 0; m_last = 0; m_code = '0; m_flg = '0; m_bad = '0;
      end else if (!m_started) begin
        m_started = 1;
        m_avail   = cyc;
      end else if (m_end == cyc - 1) begin
        m_code = {rx_errs[0] & ~m_ovf, m_ovf, rx_errs};
        m_flg  = rx_flg;
        if (!m_code[7] && m_bad < 8'd255) m_bad = m_bad + 8'd1;
        m_rep = 1;
      end else if (m_rep) begin
        if (resp_ready) begin
          m_rep = 0; m_nb = 0; m_avail = cyc + HOLD;
        end
      end else if (m_en_prev) begin
        if (d_rdy) begin
          m_nb++;
          m_last = cyc;
          if (m_nb == MAXB) begin m_ovf = 1; m_end = cyc; m_avail = NEVER; end
        end else if (m_nb > 0 && cyc == m_last + GAP) begin
          m_ovf = 0; m_end = cyc; m_avail = NEVER;
        end
      end
      @(negedge clk);
      exp_en = m_started && (cyc >= m_avail);
      if (!n_rst) begin
        chk("rst_outs", {5'd0, rx_en, rx_msg_end, resp_valid, resp_code, msg_flg, bad_cnt}, 32'd0);
        m_en_prev = 0;
      end else begin
        chk("rx_en",      rx_en,      exp_en);
        chk("rx_msg_end", rx_msg_end, (cyc == m_end));
        chk("resp_valid", resp_valid, m_rep);
        chk("resp_code",  resp_code,  m_code);
        chk("msg_flg",    msg_flg,    m_flg);
        chk("bad_cnt",    bad_cnt,    m_bad);
        m_en_prev = exp_en;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(output int c0);
    @(negedge clk);
    d_rdy = 1'b1;
    c0 = cyc;
    @(negedge clk);
    d_rdy = 1'b0;
  endtask

  task automatic wait_end(output int c);
    bit seen;
    seen = 0;
    c = -1;
    for (int i = 0; i < 300; i++) begin
      if (rx_msg_end) begin seen = 1; c = cyc; break; end
      @(negedge clk);
    end
    if (!seen) chk("end_timeout", 0, 1);
  endtask

  // Called in the rx_msg_end cycle; returns once rx_en is back.
  task automatic handshake(input int delay, input logic [7:0] code);
    int k;
    @(negedge clk);
    chk("valid_rise", resp_valid, 1);
    chk("code_rise", resp_code, code);
    idle(delay);
    chk("valid_held", resp_valid, 1);
    chk("code_held", resp_code, code);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && !rx_en; i++) begin
      k++;
      @(negedge clk);
    end
    chk("hold_len", k, HOLD);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int c0, cl, ce, n;
    idle(2);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_code", resp_code, 0);
    @(posedge clk); #3 n_rst = 1'b1;
    @(negedge clk);
    chk("rx_en_before_clk", rx_en, 0);
    @(negedge clk);
    chk("rx_en_after_clk", rx_en, 1);
    idle(2);

    // 8 bytes spaced 10 clks, ok message
    rx_errs = 6'b000001; rx_flg = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_byte(cl);
      if (i != 7) idle(9);
    end
    wait_end(ce);
    chk("gap_latency", ce - cl, 65);
    handshake(0, 8'h81);
    chk("ok_bad_cnt", bad_cnt, 0);
    chk("ok_flg", msg_flg, 8'hA5);

    // byte lands when the timer sits at 63: message continues
    rx_flg = 8'h5A;
    send_byte(c0);
    idle(62);
    send_byte(cl);
    chk("late_byte_spacing", cl - c0, 64);
    wait_end(ce);
    chk("late_byte_end", ce - c0, 129);
    handshake(3, 8'h81);

    // 70 contiguous bytes -> overflow, extras ignored
    ce = -1;
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 75; i++) begin
      if (i > 0) @(negedge clk);
      d_rdy = 1'b1;
      if (rx_msg_end) ce = cyc;
    end
    d_rdy = 1'b0;
    chk("ovf_end_cycle", ce - c0, 70);
    @(negedge clk);
    handshake(0, 8'h41);
    chk("ovf_bad_cnt", bad_cnt, 1);

    // crc error, transmitter stalls 20 clks
    rx_errs = 6'b100000; rx_flg = 8'h3C;
    send_byte(cl);
    wait_end(ce);
    handshake(20, 8'h20);
    chk("crc_bad_cnt", bad_cnt, 2);
    chk("crc_flg", msg_flg, 8'h3C);

    // reset mid-message
    rx_errs = 6'b000001;
    for (int i = 0; i < 3; i++) begin send_byte(cl); idle(4); end
    @(posedge clk); #3 n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {rx_en, rx_msg_end, resp_valid, resp_code, msg_flg, bad_cnt}, 0);
    idle(2);
    @(posedge clk); #3 n_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_msg_end || resp_valid) n++;
    end
    chk("midrst_no_resp", n, 0);
    rx_flg = 8'h77;
    send_byte(cl);
    wait_end(ce);
    chk("post_rst_latency", ce - cl, 65);
    handshake(1, 8'h81);
    chk("post_rst_flg", msg_flg, 8'h77);

    // saturation of bad_cnt
    rx_errs = 6'b000000;
    for (int i = 0; i < 260; i++) begin
      send_byte(cl);
      wait_end(ce);
      handshake(0, 8'h00);
      if (i == 253) chk("bad_254", bad_cnt, 254);
    end
    chk("bad_sat", bad_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
